div_ctrl: RTL and testbench
===========================

# div_ctrl

Issue and sign-handling controller that sits directly upstream of the iterative unsigned 64-step divider. It accepts DIV/DIVU/REM/REMU requests from the execute stage over a valid/ready handshake and converts signed operands to magnitudes. It launches the divider with a one-cycle start pulse, waits for its done flag, and then applies sign and divide-by-zero correction. The 32-bit result is held until the consumer accepts it.

## Interface
- `XLEN`, default 32: operand and result width; must match the divider width.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller can accept a request (high only in IDLE).
- `req_op` in 2: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `req_a` in XLEN: dividend.
- `req_b` in XLEN: divisor.
- `kill` in 1: abandon the in-flight operation (pipeline flush).
- `resp_valid` out 1: result valid.
- `resp_ready` in 1: consumer takes the result.
- `resp_data` out XLEN: quotient or remainder.
- `busy` out 1: high in any state other than IDLE; used for the stall.
- `div_start` out 1: start pulse to the divider.
- `div_dividend` out XLEN: unsigned dividend to the divider.
- `div_divisor` out XLEN: unsigned divisor to the divider.
- `div_done` in 1: divider done flag.
- `div_quotient` in XLEN: divider quotient.
- `div_remainder` in XLEN: divider remainder.

## Operation
- States: IDLE, LAUNCH, WAIT, RESP.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`, latch op, sign_q = a[31]^b[31], sign_r = a[31], and b_zero = (b==0).
  - Signed ops latch |a| and |b|; unsigned ops latch raw values.
  - Next state is LAUNCH.
- **LAUNCH**
  - `div_start`=1 for exactly this cycle; `div_dividend`/`div_divisor` are driven from the latched magnitudes.
  - The magnitudes stay stable through WAIT.
  - Next state is WAIT.
- **WAIT**
  - `div_done` is ignored in LAUNCH and sampled only in WAIT, because a stale done from the previous operation may be high before the start pulse is taken.
  - On `div_done`=1, register the corrected result and go to RESP.
- **Correction**
  - Quotient: DIV negates when sign_q=1.
  - Remainder: REM negates when sign_r=1.
  - b_zero overrides: quotient = all ones (DIV and DIVU), remainder = raw `req_a` (REM and REMU).
  - INT_MIN / -1 needs no special case: it yields quotient 0x80000000 and remainder 0 through the normal path (two's-complement wrap).
- **RESP**
  - `resp_valid`=1 and `resp_data` are held stable until `resp_valid && resp_ready`, then go to IDLE.
  - A new request is not accepted in the same cycle as the response handshake.
- **kill**
  - In LAUNCH, WAIT or RESP, `kill` forces IDLE on the next edge: no response, `resp_valid` drops, no start pulse.
  - The divider may keep iterating; its output is discarded.
  - `kill` in IDLE has no effect. A request accepted in IDLE is not cancelled by `kill` in that same cycle.

## Timing
- Reset (`rst_n`=0 at an edge):
  - state is IDLE;
  - `resp_valid`=0, `div_start`=0, `busy`=0;
  - `resp_data`, `div_dividend` and `div_divisor` are 0.
- Reset mid-operation behaves as `kill`. The next launch reloads the divider counter, so no divider reset is needed.
- Request accepted at edge E0:
  - LAUNCH in cycle 1;
  - divider counter is 64 in cycle 2;
  - `div_done` first seen in cycle 66;
  - result registered at E66;
  - `resp_valid` high from cycle 67.
- Throughput is one operation per 68+ cycles: IDLE occupies one cycle after each response.
- `busy` is registered and rises the cycle after acceptance.

## Configuration
- `DIV_CTRL_ZERO_BYPASS_EN`
  - **Defined:** a request with b==0 goes IDLE→RESP directly. No `div_start` is issued and `resp_valid` rises in cycle 1.
  - **Undefined:** a b==0 request follows the full LAUNCH/WAIT path.
  - The result value is identical in both builds; only latency differs.

## Test plan
- DIV a=-7 (0xFFFFFFF9), b=2 -> `resp_data`=0xFFFFFFFD (-3), `resp_valid` at accept+67, exactly one `div_start` pulse.
- REM a=-7, b=2 -> 0xFFFFFFFF. REMU a=7, b=0 -> 7. DIVU a=5, b=0 -> 0xFFFFFFFF:
  - with the macro, at accept+1 with no `div_start`;
  - without it, at accept+67.
- DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
- Hold `resp_ready`=0 for 10 cycles in RESP, with `req_valid` held high throughout -> `resp_data` stable, `req_ready`=0; after the handshake, the next request is accepted one cycle later.
- `kill` in cycle 30 of WAIT -> IDLE next cycle, no `resp_valid`. A new DIVU 100/7 issued immediately afterwards -> 14, with correct timing despite the stale divider.
- `rst_n`=0 for one cycle during RESP -> `resp_valid`=0 and `resp_data`=0 next cycle, `req_ready`=1.

Source files
------------

// File: rtl/div_ctrl.sv
// Sign/zero-correcting issue controller for a 64-step unsigned divider; `DIV_CTRL_ZERO_BYPASS_EN skips the divider when b==0.
// Latency: resp_valid 67 cycles after accept (1 with bypass on b==0); result held until resp_ready, req_ready only in IDLE.
module div_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    input  logic            kill,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic            busy,
    output logic            div_start,
    output logic [XLEN-1:0] div_dividend,
    output logic [XLEN-1:0] div_divisor,
    input  logic            div_done,
    input  logic [XLEN-1:0] div_quotient,
    input  logic [XLEN-1:0] div_remainder
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic              sign_quo_q, sign_quo_d;
    logic              sign_rem_q, sign_rem_d;
    logic              b_zero_q, b_zero_d;
    logic [XLEN-1:0]   mag_a_q, mag_a_d;
    logic [XLEN-1:0]   mag_b_q, mag_b_d;
    logic              div_start_q, div_start_d;
    logic              resp_valid_q, resp_valid_d;
    logic [XLEN-1:0]   resp_data_q, resp_data_d;
    logic              busy_q, busy_d;

    logic              req_signed;
    logic              op_signed;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   raw_a;
    logic [XLEN-1:0]   result;

    assign req_signed = ~req_op[0];
    assign op_signed  = ~op_q[0];

    // Negating |a| back with the remainder sign recovers the original dividend, so raw a need not be stored.
    always_comb begin
        quo_fix = (op_signed && sign_quo_q) ? -div_quotient  : div_quotient;
        rem_fix = (op_signed && sign_rem_q) ? -div_remainder : div_remainder;
        raw_a   = (op_signed && sign_rem_q) ? -mag_a_q       : mag_a_q;
        if (b_zero_q) begin
            quo_fix = '1;
            rem_fix = raw_a;
        end
        result = op_q[1] ? rem_fix : quo_fix;
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        sign_quo_d   = sign_quo_q;
        sign_rem_d   = sign_rem_q;
        b_zero_d     = b_zero_q;
        mag_a_d      = mag_a_q;
        mag_b_d      = mag_b_q;
        div_start_d  = 1'b0;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d        = req_op;
                    sign_quo_d  = req_a[XLEN-1] ^ req_b[XLEN-1];
                    sign_rem_d  = req_a[XLEN-1];
                    b_zero_d    = (req_b == '0);
                    mag_a_d     = (req_signed && req_a[XLEN-1]) ? -req_a : req_a;
                    mag_b_d     = (req_signed && req_b[XLEN-1]) ? -req_b : req_b;
                    state_d     = S_LAUNCH;
                    div_start_d = 1'b1;
`ifdef DIV_CTRL_ZERO_BYPASS_EN
                    if (req_b == '0) begin
                        state_d      = S_RESP;
                        div_start_d  = 1'b0;
                        resp_valid_d = 1'b1;
                        resp_data_d  = req_op[1] ? req_a : '1;
                    end
`endif
                end
            end
            S_LAUNCH: state_d = S_WAIT;
            // done is only trusted here: it may still be high from the previous operation during LAUNCH
            S_WAIT: begin
                if (div_done) begin
                    resp_data_d  = result;
                    resp_valid_d = 1'b1;
                    state_d      = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (kill && state_q != S_IDLE) begin
            state_d      = S_IDLE;
            resp_valid_d = 1'b0;
            div_start_d  = 1'b0;
        end
    end

    assign busy_d = (state_d != S_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            op_q         <= 2'd0;
            sign_quo_q   <= 1'b0;
            sign_rem_q   <= 1'b0;
            b_zero_q     <= 1'b0;
            mag_a_q      <= '0;
            mag_b_q      <= '0;
            div_start_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            sign_quo_q   <= sign_quo_d;
            sign_rem_q   <= sign_rem_d;
            b_zero_q     <= b_zero_d;
            mag_a_q      <= mag_a_d;
            mag_b_q      <= mag_b_d;
            div_start_q  <= div_start_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            busy_q       <= busy_d;
        end
    end

    assign req_ready    = (state_q == S_IDLE);
    assign resp_valid   = resp_valid_q;
    assign resp_data    = resp_data_q;
    assign busy         = busy_q;
    assign div_start    = div_start_q;
    assign div_dividend = mag_a_q;
    assign div_divisor  = mag_b_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl: behavioural 64-step divider plus arithmetic reference for DIV/DIVU/REM/REMU results and timing.
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        kill;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        busy;
    logic        div_start;
    logic [31:0] div_dividend;
    logic [31:0] div_divisor;
    logic        div_done;
    logic [31:0] div_quotient;
    logic [31:0] div_remainder;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    div_ctrl #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .kill(kill),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .busy(busy), .div_start(div_start),
        .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_done(div_done), .div_quotient(div_quotient), .div_remainder(div_remainder)
    );

    // Divider: counter reloads to 64 on start, done while counter is 0 (stays high until next start).
    logic [6:0]  dcnt = 7'd0;
    logic        drun = 1'b0;
    logic [31:0] dd   = 32'd0;
    logic [31:0] dv   = 32'd1;

    always @(posedge clk) begin
        if (div_start) begin
            dcnt <= 7'd64;
            drun <= 1'b1;
            dd   <= div_dividend;
            dv   <= div_divisor;
        end else if (drun && dcnt != 7'd0) begin
            dcnt <= dcnt - 7'd1;
        end
    end

    assign div_done      = drun && (dcnt == 7'd0);
    assign div_quotient  = (dv == 32'd0) ? 32'hFFFF_FFFF : dd / dv;
    assign div_remainder = (dv == 32'd0) ? dd : dd % dv;

    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        case (op)
            2'd0:    r = (b == 32'd0) ? -64'sd1 : sa / sb;
            2'd1:    r = (b == 32'd0) ? 64'sd4294967295 : ua / ub;
            2'd2:    r = (b == 32'd0) ? sa : sa % sb;
            default: r = (b == 32'd0) ? ua : ua % ub;
        endcase
        return r[31:0];
    endfunction

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called 1 time unit after an edge while IDLE; returns in cycle 1 after acceptance.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic with_kill);
        chk1("req_ready_idle", req_ready, 1'b1);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        kill      = with_kill;
        @(posedge clk); #1;
        req_valid = 1'b0;
        kill      = 1'b0;
    endtask

    task automatic wait_resp(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int cyc;
        int starts;
        int exp_lat;
        int exp_starts;
        exp_lat    = 67;
        exp_starts = 1;
`ifdef DIV_CTRL_ZERO_BYPASS_EN
        if (b == 32'd0) begin
            exp_lat    = 1;
            exp_starts = 0;
        end
`endif
        chk1({tag, "_busy"}, busy, 1'b1);
        cyc    = 1;
        starts = 0;
        while (!resp_valid && cyc < 200) begin
            starts += int'(div_start);
            @(posedge clk); #1;
            cyc++;
        end
        chk_int({tag, "_latency"}, cyc, exp_lat);
        chk_int({tag, "_starts"}, starts, exp_starts);
        chk32({tag, "_data"}, resp_data, ref_result(op, a, b));
    endtask

    task automatic handshake(input string tag);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk1({tag, "_valid_drop"}, resp_valid, 1'b0);
        chk1({tag, "_idle_ready"}, req_ready, 1'b1);
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        issue(op, a, b, 1'b0);
        wait_resp(tag, op, a, b);
        handshake(tag);
    endtask

    logic [31:0] held;
    logic [31:0] ra, rb;
    logic [1:0]  rop;

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_op = 2'd0; req_a = 32'd0; req_b = 32'd0;
        kill = 1'b0; resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk1("rst_resp_valid", resp_valid, 1'b0);
        chk1("rst_div_start", div_start, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_req_ready", req_ready, 1'b1);
        chk32("rst_resp_data", resp_data, 32'd0);
        chk32("rst_dividend", div_dividend, 32'd0);
        chk32("rst_divisor", div_divisor, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("div_m7_2", 2'd0, 32'hFFFF_FFF9, 32'd2);
        run_op("rem_m7_2", 2'd2, 32'hFFFF_FFF9, 32'd2);
        run_op("remu_7_0", 2'd3, 32'd7, 32'd0);
        run_op("divu_5_0", 2'd1, 32'd5, 32'd0);
        run_op("div_m9_0", 2'd0, 32'hFFFF_FFF7, 32'd0);
        run_op("rem_m9_0", 2'd2, 32'hFFFF_FFF7, 32'd0);
        run_op("div_min_m1", 2'd0, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("rem_min_m1", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF);

        // Backpressure: response held while a new request waits
        issue(2'd1, 32'd1000, 32'd10, 1'b0);
        wait_resp("hold_first", 2'd1, 32'd1000, 32'd10);
        held      = resp_data;
        req_valid = 1'b1; req_op = 2'd0; req_a = 32'd100; req_b = 32'hFFFF_FFF9;
        repeat (10) begin
            @(posedge clk); #1;
            chk32("hold_data", resp_data, held);
            chk1("hold_valid", resp_valid, 1'b1);
            chk1("hold_req_ready", req_ready, 1'b0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk1("hold_valid_drop", resp_valid, 1'b0);
        chk1("hold_idle_ready", req_ready, 1'b1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk1("hold_next_accepted", req_ready, 1'b0);
        wait_resp("hold_second", 2'd0, 32'd100, 32'hFFFF_FFF9);
        handshake("hold_second");

        // Kill in WAIT, then a fresh op must run its full length on the stale divider
        issue(2'd0, 32'd12345, 32'd17, 1'b0);
        repeat (30) begin @(posedge clk); #1; end
        chk1("kill_pre_valid", resp_valid, 1'b0);
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        chk1("kill_busy", busy, 1'b0);
        chk1("kill_req_ready", req_ready, 1'b1);
        chk1("kill_valid", resp_valid, 1'b0);
        run_op("divu_100_7", 2'd1, 32'd100, 32'd7);

        // Kill in IDLE does not cancel the request accepted that cycle
        issue(2'd2, 32'd50, 32'hFFFF_FFFA, 1'b1);
        wait_resp("kill_idle", 2'd2, 32'd50, 32'hFFFF_FFFA);
        handshake("kill_idle");

        // Kill in RESP drops the response
        issue(2'd3, 32'd99, 32'd10, 1'b0);
        wait_resp("kill_resp", 2'd3, 32'd99, 32'd10);
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        chk1("kill_resp_valid", resp_valid, 1'b0);
        chk1("kill_resp_ready", req_ready, 1'b1);

        // One-cycle reset during RESP
        issue(2'd0, 32'hFFFF_FF00, 32'd3, 1'b0);
        wait_resp("rst_resp", 2'd0, 32'hFFFF_FF00, 32'd3);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk1("rst_mid_valid", resp_valid, 1'b0);
        chk32("rst_mid_data", resp_data, 32'd0);
        chk1("rst_mid_ready", req_ready, 1'b1);
        chk1("rst_mid_busy", busy, 1'b0);
        run_op("after_rst", 2'd0, 32'd77, 32'hFFFF_FFFE);

        for (int i = 0; i < 16; i++) begin
            rop = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       ra = 32'h8000_0000;
                1:       ra = 32'($urandom_range(0, 40)) - 32'd20;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = 32'($urandom_range(0, 20)) - 32'd10;
                default: rb = $urandom >> $urandom_range(0, 28);
            endcase
            run_op("rand", rop, ra, rb);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
